// File: rtl/sys_mode_ctrl_if.sv
// sys_mode_ctrl_if: button/status bundle for the system mode controller.
// master = board/bench side, slave = controller side.
interface sys_mode_ctrl_if;
    logic       work_btn;
    logic       uart_btn;
    logic       step_btn;
    logic       uart_done;
    logic       mode_work;
    logic       uart_rst;
    logic       cpu_rst;
    logic       cpu_en;
    logic [1:0] state;

    modport master (
        output work_btn, uart_btn, step_btn, uart_done,
        input  mode_work, uart_rst, cpu_rst, cpu_en, state
    );

    modport slave (
        input  work_btn, uart_btn, step_btn, uart_done,
        output mode_work, uart_rst, cpu_rst, cpu_en, state
    );
endinterface

// File: rtl/sys_mode_ctrl.sv
// sys_mode_ctrl: UART-upload / warm-up / run / single-step mode sequencer.
// Optional STEP state and step button built only when SYS_MODE_STEP_EN is defined.

// Button conditioner: 2-flop synchroniser, saturating debouncer, rise pulse.
module sys_mode_deb #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic fpga_clk,
    input  logic rst_ctrl,
    input  logic din,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          lvl_q;
    logic          lvl_d1_q;
    logic [CW-1:0] cnt_q;

    // Bring the raw button into the clock domain.
    always_ff @(posedge fpga_clk or posedge rst_ctrl) begin
        if (rst_ctrl) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], din};
    end

    // Count consecutive samples that disagree with the accepted level.
    always_ff @(posedge fpga_clk or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else if (sync_q[1] == lvl_q) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            lvl_q <= sync_q[1];
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Delayed accepted level for press detection.
    always_ff @(posedge fpga_clk or posedge rst_ctrl) begin
        if (rst_ctrl) lvl_d1_q <= 1'b0;
        else          lvl_d1_q <= lvl_q;
    end

    assign rise = lvl_q & ~lvl_d1_q;
endmodule

module sys_mode_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int EN_DELAY    = 256,
    parameter int AUTO_RETURN = 1
) (
    input  logic           fpga_clk,
    input  logic           rst_ctrl,
    sys_mode_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_UART = 2'b00,
        S_WARM = 2'b01,
        S_RUN  = 2'b10,
        S_STEP = 2'b11
    } state_t;

    localparam int WCW = $clog2(EN_DELAY) + 1;
    localparam logic [WCW-1:0] WARM_LAST = WCW'(EN_DELAY - 1);

    state_t         cur_q;
    state_t         nxt;
    logic [WCW-1:0] wcnt_q;
    logic [2:0]     done_q;
    logic           work_ev;
    logic           uart_ev;
    logic           done_ev;
    logic           auto_ret;
    logic           step_pulse;

    logic           mode_work_q;
    logic           uart_rst_q;
    logic           cpu_rst_q;
    logic           cpu_en_q;
    logic           mode_work_d;
    logic           uart_rst_d;
    logic           cpu_rst_d;
    logic           cpu_en_d;

    sys_mode_deb #(.DEB_CYCLES(DEB_CYCLES)) u_work_deb (
        .fpga_clk (fpga_clk),
        .rst_ctrl (rst_ctrl),
        .din      (bus.work_btn),
        .rise     (work_ev)
    );

    sys_mode_deb #(.DEB_CYCLES(DEB_CYCLES)) u_uart_deb (
        .fpga_clk (fpga_clk),
        .rst_ctrl (rst_ctrl),
        .din      (bus.uart_btn),
        .rise     (uart_ev)
    );

`ifdef SYS_MODE_STEP_EN
    logic step_ev;

    sys_mode_deb #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .fpga_clk (fpga_clk),
        .rst_ctrl (rst_ctrl),
        .din      (bus.step_btn),
        .rise     (step_ev)
    );
`else
    logic unused_step;
    assign unused_step = bus.step_btn;
`endif

    assign auto_ret = (AUTO_RETURN != 0);

    // Synchronise uart_done; third flop gives the previous sample.
    always_ff @(posedge fpga_clk or posedge rst_ctrl) begin
        if (rst_ctrl) done_q <= 3'b000;
        else          done_q <= {done_q[1:0], bus.uart_done};
    end

    assign done_ev = done_q[1] & ~done_q[2];

    // Next-state decode; cpu_rst_q high in WARMUP marks the post-reset entry cycle.
    always_comb begin
        nxt        = cur_q;
        step_pulse = 1'b0;
        case (cur_q)
            S_UART: begin
                if (work_ev)                   nxt = S_WARM;
                else if (done_ev && auto_ret)  nxt = S_WARM;
            end
            S_WARM: begin
                if (uart_ev)
                    nxt = S_UART;
                else if (!cpu_rst_q && wcnt_q == WARM_LAST)
                    nxt = S_RUN;
            end
            S_RUN: begin
                if (uart_ev)      nxt = S_UART;
`ifdef SYS_MODE_STEP_EN
                else if (step_ev) nxt = S_STEP;
`endif
            end
`ifdef SYS_MODE_STEP_EN
            S_STEP: begin
                if (work_ev)      nxt = S_RUN;
                else if (uart_ev) nxt = S_UART;
                else if (step_ev) step_pulse = 1'b1;
            end
`endif
            default: nxt = S_WARM;
        endcase
    end

    // Output decode from the next state so outputs move with state.
    always_comb begin
        mode_work_d = 1'b1;
        uart_rst_d  = 1'b1;
        cpu_rst_d   = 1'b0;
        cpu_en_d    = 1'b0;
        case (nxt)
            S_UART: begin
                mode_work_d = 1'b0;
                uart_rst_d  = 1'b0;
                cpu_rst_d   = 1'b1;
            end
            S_RUN:   cpu_en_d = 1'b1;
            S_STEP:  cpu_en_d = step_pulse;
            default: cpu_en_d = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge fpga_clk or posedge rst_ctrl) begin
        if (rst_ctrl) cur_q <= S_WARM;
        else          cur_q <= nxt;
    end

    // Registered outputs; reset holds CPU in reset inside WARMUP.
    always_ff @(posedge fpga_clk or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            mode_work_q <= 1'b1;
            uart_rst_q  <= 1'b1;
            cpu_rst_q   <= 1'b1;
            cpu_en_q    <= 1'b0;
        end else begin
            mode_work_q <= mode_work_d;
            uart_rst_q  <= uart_rst_d;
            cpu_rst_q   <= cpu_rst_d;
            cpu_en_q    <= cpu_en_d;
        end
    end

    // Warm-up timer: zero outside WARMUP, so every entry starts from 0.
    always_ff @(posedge fpga_clk or posedge rst_ctrl) begin
        if (rst_ctrl)
            wcnt_q <= '0;
        else if (cur_q != S_WARM || cpu_rst_q)
            wcnt_q <= '0;
        else if (wcnt_q != '1)
            wcnt_q <= wcnt_q + 1'b1;
    end

    assign bus.state     = cur_q;
    assign bus.mode_work = mode_work_q;
    assign bus.uart_rst  = uart_rst_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.cpu_en    = cpu_en_q;
endmodule

// File: tb/tb_sys_mode_ctrl.sv
// tb_sys_mode_ctrl: directed checks of the mode sequencer.
// DEB_CYCLES=4, EN_DELAY=8, AUTO_RETURN=1.
module tb_sys_mode_ctrl;
    logic fpga_clk = 1'b0;
    logic rst_ctrl = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // outs = {state, cpu_rst, cpu_en, uart_rst, mode_work}
    localparam logic [5:0] RST_V  = 6'b01_1011;
    localparam logic [5:0] WARM_V = 6'b01_0011;
    localparam logic [5:0] RUN_V  = 6'b10_0111;
    localparam logic [5:0] UART_V = 6'b00_1000;
    localparam logic [5:0] STEP_V = 6'b11_0011;

    sys_mode_ctrl_if bus ();

    sys_mode_ctrl #(
        .DEB_CYCLES  (4),
        .EN_DELAY    (8),
        .AUTO_RETURN (1)
    ) dut (
        .fpga_clk (fpga_clk),
        .rst_ctrl (rst_ctrl),
        .bus      (bus.slave)
    );

    logic [5:0] outs;
    assign outs = {bus.state, bus.cpu_rst, bus.cpu_en,
                   bus.uart_rst, bus.mode_work};

    always #5 fpga_clk = ~fpga_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fpga_clk);
            @(negedge fpga_clk);
        end
    endtask

    task automatic test_reset();
        bus.work_btn  = 1'b0;
        bus.uart_btn  = 1'b0;
        bus.step_btn  = 1'b0;
        bus.uart_done = 1'b0;
        #1 rst_ctrl = 1'b1;
        tick(3);
        n_cmp++;
        if (outs !== RST_V) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", outs, RST_V);
        end
    endtask

    task automatic test_warmup();
        rst_ctrl = 1'b0;
        tick(1);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL warm_entry: got %b want %b", outs, WARM_V);
        end
        tick(6);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL warm_mid: got %b want %b", outs, WARM_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL warm_last: got %b want %b", outs, WARM_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL run_at_8: got %b want %b", outs, RUN_V);
        end
    endtask

    task automatic test_uart_entry();
        bus.uart_btn = 1'b1;
        tick(6);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL uart_early: got %b want %b", outs, RUN_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== UART_V) begin
            n_bad++;
            $display("FAIL uart_at_7: got %b want %b", outs, UART_V);
        end
        tick(3);
        bus.uart_btn = 1'b0;
        tick(10);
        n_cmp++;
        if (outs !== UART_V) begin
            n_bad++;
            $display("FAIL uart_release: got %b want %b", outs, UART_V);
        end
        bus.uart_done = 1'b1;
        tick(2);
        n_cmp++;
        if (outs !== UART_V) begin
            n_bad++;
            $display("FAIL done_early: got %b want %b", outs, UART_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL done_return: got %b want %b", outs, WARM_V);
        end
        bus.uart_done = 1'b0;
        tick(7);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL rewarm_last: got %b want %b", outs, WARM_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL rewarm_run: got %b want %b", outs, RUN_V);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 10; i++) begin
            bus.uart_btn = ~bus.uart_btn;
            tick(2);
            n_cmp++;
            if (outs !== RUN_V) begin
                n_bad++;
                $display("FAIL glitch_%0d: got %b want %b", i, outs, RUN_V);
            end
        end
        bus.uart_btn = 1'b0;
        tick(8);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL glitch_settle: got %b want %b", outs, RUN_V);
        end
    endtask

`ifdef SYS_MODE_STEP_EN
    task automatic test_step();
        int hi;
        int first;
        hi    = 0;
        first = -1;
        bus.step_btn = 1'b1;
        tick(7);
        n_cmp++;
        if (outs !== STEP_V) begin
            n_bad++;
            $display("FAIL step_enter: got %b want %b", outs, STEP_V);
        end
        bus.step_btn = 1'b0;
        tick(10);
        n_cmp++;
        if (outs !== STEP_V) begin
            n_bad++;
            $display("FAIL step_idle: got %b want %b", outs, STEP_V);
        end
        bus.step_btn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 51) bus.step_btn = 1'b0;
            tick(1);
            if (bus.cpu_en === 1'b1) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (hi !== 1) begin
            n_bad++;
            $display("FAIL step_pulse_len: got %0d want 1", hi);
        end
        n_cmp++;
        if (first !== 7) begin
            n_bad++;
            $display("FAIL step_pulse_at: got %0d want 7", first);
        end
        bus.work_btn = 1'b1;
        tick(7);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL work_resume: got %b want %b", outs, RUN_V);
        end
        bus.work_btn = 1'b0;
        tick(10);
        bus.step_btn = 1'b1;
        tick(7);
        bus.step_btn = 1'b0;
        tick(10);
        bus.step_btn = 1'b1;
        bus.uart_btn = 1'b1;
        tick(7);
        n_cmp++;
        if (outs !== UART_V) begin
            n_bad++;
            $display("FAIL clash_uart: got %b want %b", outs, UART_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== UART_V) begin
            n_bad++;
            $display("FAIL clash_no_pulse: got %b want %b", outs, UART_V);
        end
        bus.step_btn = 1'b0;
        bus.uart_btn = 1'b0;
        tick(10);
    endtask
`else
    task automatic test_step();
        bus.step_btn = 1'b1;
        tick(7);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL step_ignored: got %b want %b", outs, RUN_V);
        end
        tick(13);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL step_ignored_hold: got %b want %b", outs, RUN_V);
        end
        bus.step_btn = 1'b0;
        tick(10);
        bus.uart_btn = 1'b1;
        tick(7);
        n_cmp++;
        if (outs !== UART_V) begin
            n_bad++;
            $display("FAIL uart_again: got %b want %b", outs, UART_V);
        end
        bus.uart_btn = 1'b0;
        tick(10);
    endtask
`endif

    task automatic test_work_wins();
        bus.work_btn = 1'b1;
        bus.uart_btn = 1'b1;
        tick(6);
        n_cmp++;
        if (outs !== UART_V) begin
            n_bad++;
            $display("FAIL both_early: got %b want %b", outs, UART_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL work_wins: got %b want %b", outs, WARM_V);
        end
        bus.work_btn = 1'b0;
        bus.uart_btn = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick(5);
        #2 rst_ctrl = 1'b1;
        #1;
        n_cmp++;
        if (outs !== RST_V) begin
            n_bad++;
            $display("FAIL async_rst: got %b want %b", outs, RST_V);
        end
        tick(3);
        n_cmp++;
        if (outs !== RST_V) begin
            n_bad++;
            $display("FAIL rst_hold: got %b want %b", outs, RST_V);
        end
        rst_ctrl = 1'b0;
        tick(1);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL rst_entry: got %b want %b", outs, WARM_V);
        end
        tick(7);
        n_cmp++;
        if (outs !== WARM_V) begin
            n_bad++;
            $display("FAIL rst_warm_last: got %b want %b", outs, WARM_V);
        end
        tick(1);
        n_cmp++;
        if (outs !== RUN_V) begin
            n_bad++;
            $display("FAIL rst_run: got %b want %b", outs, RUN_V);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_uart_entry();
        test_glitch();
        test_step();
        test_work_wins();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
